// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller and its loop-sensor front end.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        PRESENT = 3'd2,
        HOLD    = 3'd3,
        FAULT   = 3'd4
    } sensor_state_t;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

endpackage

// File: rtl/loop_sensor_channel.sv
// One inductive-loop channel: synchronizer, debounce, gap hold and stuck-on fault detection.
module loop_sensor_channel
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
    parameter int unsigned GAP_HOLD_CYCLES = 32'd300_000_000,
    parameter int unsigned STUCK_CYCLES    = 32'd3_000_000_000,
    parameter logic        FAIL_SAFE_LEVEL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic sensor_o,
    output logic fault_o,
    output logic fault_entry_o
);

    localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] STUCK_TC = CNT_W'(STUCK_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic          sync1_q, sync2_q;
    logic          raw_s;
    sensor_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          sensor_q, sensor_d;
    logic          fault_q, fault_d;

    assign raw_s = sync2_q;

    // Synchronizer, state, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            sensor_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sensor_q <= sensor_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and counter; terminal counts are compare-equal so cnt never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (raw_s) begin
                    state_d = QUALIFY;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            QUALIFY: begin
                if (!raw_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DEB_TC) begin
                    state_d = PRESENT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            PRESENT: begin
                if (!raw_s) begin
                    state_d = HOLD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STUCK_TC) begin
                    state_d = FAULT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (raw_s) begin
                    state_d = PRESENT;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == GAP_TC) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            FAULT: begin
                // Any presence restarts the clean-input qualification window.
                if (raw_s) begin
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DEB_TC) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state so outputs move on the same edge as the state.
    always_comb begin
        sensor_d = 1'b0;
        fault_d  = 1'b0;
        case (state_d)
            IDLE:    begin sensor_d = 1'b0;            fault_d = 1'b0; end
            QUALIFY: begin sensor_d = 1'b0;            fault_d = 1'b0; end
            PRESENT: begin sensor_d = 1'b1;            fault_d = 1'b0; end
            HOLD:    begin sensor_d = 1'b1;            fault_d = 1'b0; end
            FAULT:   begin sensor_d = FAIL_SAFE_LEVEL; fault_d = 1'b1; end
            default: begin sensor_d = 1'b0;            fault_d = 1'b0; end
        endcase
    end

    assign sensor_o      = sensor_q;
    assign fault_o       = fault_q;
    assign fault_entry_o = (state_d == FAULT) && (state_q != FAULT);

endmodule

// File: rtl/loop_sensor_conditioner.sv
// Conditions main/side raw loop detectors into clean demand signals with shared sticky fault status.
module loop_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
    parameter int unsigned GAP_HOLD_CYCLES = 32'd300_000_000,
    parameter int unsigned STUCK_CYCLES    = 32'd3_000_000_000,
    parameter logic        FAIL_SAFE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       main_loop_raw,
    input  logic       side_loop_raw,
    input  logic       fault_clr,
    output logic       main_road_sensor,
    output logic       side_road_sensor,
    output logic       main_loop_fault,
    output logic       side_loop_fault,
    output logic [1:0] fault_sticky
);

    logic [1:0] fault_entry_s;
    logic [1:0] sticky_q, sticky_d;

    loop_sensor_channel #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .GAP_HOLD_CYCLES (GAP_HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .FAIL_SAFE_LEVEL (FAIL_SAFE_LEVEL)
    ) u_main (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .raw_i         (main_loop_raw),
        .sensor_o      (main_road_sensor),
        .fault_o       (main_loop_fault),
        .fault_entry_o (fault_entry_s[0])
    );

    loop_sensor_channel #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .GAP_HOLD_CYCLES (GAP_HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .FAIL_SAFE_LEVEL (FAIL_SAFE_LEVEL)
    ) u_side (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .raw_i         (side_loop_raw),
        .sensor_o      (side_road_sensor),
        .fault_o       (side_loop_fault),
        .fault_entry_o (fault_entry_s[1])
    );

    // Fault entry takes priority over a coincident clear.
    always_comb begin
        sticky_d = fault_entry_s | (sticky_q & ~{2{fault_clr}});
    end

    // Sticky fault register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign fault_sticky = sticky_q;

endmodule

// File: doc/loop_sensor_conditioner.md
Name: loop_sensor_conditioner

Overview:
- Upstream stage of the traffic light controller. Conditions raw inductive-loop detector inputs for the main and side road into the clean `main_road_sensor` / `side_road_sensor` demand signals that controller consumes.
- Per channel: 2-flop synchronizer, debounce qualification, gap-hold extension so brief detector dropouts do not drop demand, and stuck-on fault detection with a fail-safe output level.
- Contains two identical channels and shared sticky fault status.

Parameters:
- CNT_W, 32: width of all per-channel counters.
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronized input must be stable to qualify presence or clear a fault (10 ms @ 100 MHz). Must be >= 1.
- GAP_HOLD_CYCLES, 300_000_000: cycles the output is held after the detector drops (3 s). Must be >= 1.
- STUCK_CYCLES, 3_000_000_000: continuous-presence limit before fault (30 s). Must be > DEBOUNCE_CYCLES and < 2^CNT_W.
- FAIL_SAFE_LEVEL, 1'b1: sensor output value while a channel is in fault.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- main_loop_raw  input  1  raw main-road detector, asynchronous to clk
- side_loop_raw  input  1  raw side-road detector, asynchronous to clk
- fault_clr  input  1  single-cycle pulse; clears fault_sticky
- main_road_sensor  output  1  conditioned main-road demand, registered
- side_road_sensor  output  1  conditioned side-road demand, registered
- main_loop_fault  output  1  live main-channel fault (state == FAULT), registered
- side_loop_fault  output  1  live side-channel fault, registered
- fault_sticky  output  2  [0]=main, [1]=side; set on entry to FAULT, held until fault_clr

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - sync flops 0, state IDLE, counters 0.
  - All outputs 0, including fault_sticky.
- Sync: raw -> s1 -> s2 (raw_s). All decisions use raw_s only.
- Channel FSM (one counter cnt, cleared on every state change):
  - IDLE: out=0. raw_s=1 -> QUALIFY.
  - QUALIFY: out=0. raw_s=0 -> IDLE. If raw_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESENT. Otherwise cnt++.
  - PRESENT: out=1. raw_s=0 -> HOLD. If raw_s=1 and cnt==STUCK_CYCLES-1 -> FAULT. Otherwise cnt++.
  - HOLD: out=1. raw_s=1 -> PRESENT (cnt cleared, so stuck timing restarts). If raw_s=0 and cnt==GAP_HOLD_CYCLES-1 -> IDLE. Otherwise cnt++.
  - FAULT: out=FAIL_SAFE_LEVEL, live fault=1. raw_s=1 clears cnt. If raw_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++ while raw_s=0.
  - Illegal encoding -> IDLE.
- Outputs are registered and update on the same edge the state changes.
- Latency with raw stable:
  - Rise: sensor output high after edge 3+DEBOUNCE_CYCLES, where edge 1 is the first edge sampling raw=1.
  - Fall from PRESENT: output low after edge 3+GAP_HOLD_CYCLES, where edge 1 is the first edge sampling raw=0.
  - Fault: FAULT entered STUCK_CYCLES edges after PRESENT entry.
- Counter arithmetic: unsigned CNT_W-bit. Compare-equal terminal counts only, so no wrap is possible.
- fault_sticky[i]:
  - Set on the edge channel i enters FAULT.
  - Cleared by fault_clr otherwise.
  - Set and clear in the same cycle: set wins.
  - fault_clr does not affect the channel FSM.
- Channels are fully independent; simultaneous events on both channels are handled in parallel.

Decomposition:
- traffic_pkg:
  - sensor_state_t enum {IDLE, QUALIFY, PRESENT, HOLD, FAULT}, 3 bits.
  - Light-code localparams RED/YELLOW/GREEN, shared with the controller.
- Sub-module loop_sensor_channel:
  - Sync, FSM, counter, out, live fault, fault_entry pulse.
  - Instantiated twice.
- Top level holds fault_sticky and the port mapping.

Test Plan:
Use DEBOUNCE_CYCLES=4, GAP_HOLD_CYCLES=10, STUCK_CYCLES=50, FAIL_SAFE_LEVEL=1.
- Reset: assert reset_n=0 mid-HOLD with side output 1 -> all outputs 0 immediately (asynchronous). After release with raws 0, outputs remain 0.
- Glitch reject: main_loop_raw high for 3 cycles then low -> main_road_sensor never asserts; state returns to IDLE.
- Clean vehicle: side_loop_raw high for 20 cycles ->
  - side_road_sensor rises after edge 7;
  - stays 1 until 13 edges after the first edge sampling raw=0;
  - main outputs untouched.
- Dropout bridging: main presence qualified, then raw low 5 cycles, then high again -> main_road_sensor stays 1 with no gap; stuck count restarts at 0.
- Stuck detector: side raw held high 100 cycles ->
  - at PRESENT+50: side_loop_fault=1, fault_sticky=2'b10, side_road_sensor stays 1;
  - raw low 4 cycles -> fault=0 and sensor=0; sticky stays 2'b10 until fault_clr, then 2'b00.
- Set/clear collision: fault_clr pulsed on the edge the main channel enters FAULT -> fault_sticky[0]=1; simultaneous side-channel activity is unaffected.
